// File: rtl/dot_product_mac_stage_if.sv
// Handshake bundle for dot_product_mac_stage: control (start/len/busy),
// element-pair input stream and scalar result output.
interface dot_product_mac_stage_if #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 72,
  parameter int LEN_W  = 16
);
  logic              start;
  logic [LEN_W-1:0]  vec_len;
  logic              busy;

  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_a;
  logic [DATA_W-1:0] s_b;
  logic              s_last;

  logic              m_valid;
  logic              m_ready;
  logic [ACC_W-1:0]  m_result;
  logic              m_error;
  logic              m_ovf;

  modport master (
    output start, vec_len, s_valid, s_a, s_b, s_last, m_ready,
    input  busy, s_ready, m_valid, m_result, m_error, m_ovf
  );

  modport slave (
    input  start, vec_len, s_valid, s_a, s_b, s_last, m_ready,
    output busy, s_ready, m_valid, m_result, m_error, m_ovf
  );
endinterface

// File: rtl/dot_product_mac_stage.sv
// Streaming signed multiply-accumulate stage: one scalar dot product per vector.
// Define DOT_SATURATE_EN for a saturating accumulator with sticky m_ovf; otherwise it wraps.
module dot_product_mac_stage #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 72,
  parameter int LEN_W  = 16
) (
  input logic                    ACLK,
  input logic                    ARESETN,
  dot_product_mac_stage_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam int PW = 2 * DATA_W;

  state_t            state, state_nxt;
  logic [LEN_W-1:0]  len, cnt;
  logic [PW-1:0]     p_reg;
  logic              p_vld;
  logic [ACC_W-1:0]  acc, acc_add;
  logic [ACC_W:0]    sum_ext;
  logic              err;
  logic              beat, last_beat, accept_start;
  logic [PW-1:0]     a_ext, b_ext;

  assign beat         = bus.s_valid && (state == RUN);
  assign last_beat    = (cnt == len - LEN_W'(1));
  assign accept_start = (state == IDLE) && bus.start;
  assign a_ext        = {{DATA_W{bus.s_a[DATA_W-1]}}, bus.s_a};
  assign b_ext        = {{DATA_W{bus.s_b[DATA_W-1]}}, bus.s_b};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = (bus.vec_len == '0) ? DONE : RUN;
      RUN:     if (beat && last_beat) state_nxt = DRAIN;
      DRAIN:   state_nxt = DONE;
      DONE:    if (bus.m_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One extra guard bit makes the overflow test a sign-bit disagreement.
  assign sum_ext = {acc[ACC_W-1], acc} + {{(ACC_W + 1 - PW){p_reg[PW-1]}}, p_reg};

`ifdef DOT_SATURATE_EN
  logic sum_ovf;
  logic ovf;

  always_comb begin
    sum_ovf = sum_ext[ACC_W] ^ sum_ext[ACC_W-1];
    acc_add = sum_ext[ACC_W-1:0];
    if (sum_ovf)
      acc_add = sum_ext[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)
      ovf <= 1'b0;
    else if (accept_start)
      ovf <= 1'b0;
    else if (p_vld && sum_ovf)
      ovf <= 1'b1;
  end

  assign bus.m_ovf = ovf;
`else
  always_comb begin
    acc_add = sum_ext[ACC_W-1:0];
  end

  assign bus.m_ovf = 1'b0;
`endif

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state <= IDLE;
      len   <= '0;
      cnt   <= '0;
      p_reg <= '0;
      p_vld <= 1'b0;
      acc   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      p_vld <= beat;
      if (beat) begin
        p_reg <= a_ext * b_ext;
        cnt   <= cnt + LEN_W'(1);
        if (bus.s_last != last_beat) err <= 1'b1;
      end
      if (accept_start) begin
        len <= bus.vec_len;
        cnt <= '0;
        acc <= '0;
        err <= 1'b0;
      end else if (p_vld) begin
        acc <= acc_add;
      end
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.s_ready  = (state == RUN);
  assign bus.m_valid  = (state == DONE);
  assign bus.m_result = acc;
  assign bus.m_error  = err;

endmodule

// File: tb/tb_dot_product_mac_stage.sv
// Self-checking bench for dot_product_mac_stage (DATA_W=32, ACC_W=64) against an
// arithmetic reference model; honours DOT_SATURATE_EN when defined.
module tb_dot_product_mac_stage;

  localparam int DW = 32;
  localparam int AW = 64;
  localparam int LW = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dot_product_mac_stage_if #(.DATA_W(DW), .ACC_W(AW), .LEN_W(LW)) bus ();

  dot_product_mac_stage #(.DATA_W(DW), .ACC_W(AW), .LEN_W(LW)) dut (
    .ACLK    (clk),
    .ARESETN (rst_n),
    .bus     (bus)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;
  int va[64];
  int vb[64];

  // Observations from the last run_vector call
  logic [AW-1:0] r_res;
  logic          r_err, r_ovf, r_tmo, r_busy_ok, r_hold_ok, r_rdy_seen, r_mv_after;
  int            r_lat;

  // Expected values from the model
  logic [AW-1:0] e_res;
  logic          e_err, e_ovf;

  function automatic void model(input int n, input int last_idx,
                                output logic [AW-1:0] res, output logic err, output logic ovf);
    logic signed [127:0] s;
    longint prod;
`ifdef DOT_SATURATE_EN
    logic signed [127:0] maxv = {64'h0, 64'h7FFF_FFFF_FFFF_FFFF};
    logic signed [127:0] minv = {64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000};
`endif
    s = '0; err = 1'b0; ovf = 1'b0;
    for (int i = 0; i < n; i++) begin
      prod = longint'(va[i]) * longint'(vb[i]);
      s = s + {{64{prod[63]}}, prod};
`ifdef DOT_SATURATE_EN
      if (s > maxv) begin s = maxv; ovf = 1'b1; end
      else if (s < minv) begin s = minv; ovf = 1'b1; end
`else
      s = {{64{s[63]}}, s[63:0]};
`endif
      if ((i == last_idx) != (i == n - 1)) err = 1'b1;
    end
    res = s[AW-1:0];
  endfunction

  // Drives one vector and records what the DUT presented. stall_mode: 0 none,
  // 1 s_valid every other cycle, 2 random. r_lat counts clock edges from the
  // final accepted beat (or from the accepting start edge when n==0) to m_valid.
  task automatic run_vector(input int n, input int last_idx, input int stall_mode,
                            input int rdy_delay, input bit poke_start);
    int   i, guard;
    logic v, rdy;
    r_tmo = 1'b0; r_busy_ok = 1'b1; r_hold_ok = 1'b1; r_rdy_seen = 1'b0;
    bus.start = 1'b1; bus.vec_len = LW'(n);
    @(posedge clk); #1;
    bus.start = 1'b0;
    i = 0; guard = 0;
    while (i < n) begin
      if (guard > 500) begin r_tmo = 1'b1; break; end
      case (stall_mode)
        1:       v = (guard % 2 == 0);
        2:       v = ($urandom_range(0, 99) >= 30);
        default: v = 1'b1;
      endcase
      bus.s_valid = v; bus.s_a = va[i]; bus.s_b = vb[i]; bus.s_last = (i == last_idx);
      bus.start = poke_start && (guard == 2); bus.vec_len = LW'(1);
      rdy = bus.s_ready;
      if (!bus.busy) r_busy_ok = 1'b0;
      @(posedge clk); #1;
      guard++;
      if (v && rdy) i++;
    end
    bus.s_valid = 1'b0; bus.s_last = 1'b0; bus.start = 1'b0;
    r_lat = (n == 0) ? 0 : 1;
    while (!bus.m_valid && !r_tmo) begin
      if (bus.s_ready) r_rdy_seen = 1'b1;
      if (!bus.busy) r_busy_ok = 1'b0;
      if (r_lat > 50) r_tmo = 1'b1;
      else begin @(posedge clk); #1; r_lat++; end
    end
    r_res = bus.m_result; r_err = bus.m_error; r_ovf = bus.m_ovf;
    for (int k = 0; k < rdy_delay; k++) begin
      @(posedge clk); #1;
      if (bus.m_result !== r_res || bus.m_valid !== 1'b1 ||
          bus.m_error !== r_err || bus.m_ovf !== r_ovf) r_hold_ok = 1'b0;
      if (!bus.busy) r_busy_ok = 1'b0;
    end
    bus.m_ready = 1'b1;
    @(posedge clk); #1;
    bus.m_ready = 1'b0;
    r_mv_after = bus.m_valid;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    total_cnt++; if ({bus.busy, bus.s_ready, bus.m_valid, bus.m_error, bus.m_ovf} !== 5'b0)
      $display("FAIL reset_flags got %b exp 00000", {bus.busy, bus.s_ready, bus.m_valid, bus.m_error, bus.m_ovf});
    else pass_cnt++;
    total_cnt++; if (bus.m_result !== '0) $display("FAIL reset_result got %h exp 0", bus.m_result);
    else pass_cnt++;
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL reset_idle_busy got %b exp 0", bus.busy);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    va[0] = 1; va[1] = 2; va[2] = 3; va[3] = 4;
    vb[0] = 5; vb[1] = 6; vb[2] = 7; vb[3] = 8;
    run_vector(4, 3, 0, 2, 1'b1);
    total_cnt++; if (r_tmo !== 1'b0) $display("FAIL basic_timeout got %b exp 0", r_tmo); else pass_cnt++;
    total_cnt++; if (r_res !== AW'(70)) $display("FAIL basic_result got %0d exp 70", $signed(r_res)); else pass_cnt++;
    total_cnt++; if (r_err !== 1'b0) $display("FAIL basic_error got %b exp 0", r_err); else pass_cnt++;
    total_cnt++; if (r_lat !== 2) $display("FAIL basic_latency got %0d exp 2", r_lat); else pass_cnt++;
    total_cnt++; if (r_hold_ok !== 1'b1) $display("FAIL basic_hold got %b exp 1", r_hold_ok); else pass_cnt++;
    total_cnt++; if (r_mv_after !== 1'b0) $display("FAIL basic_mvalid_drop got %b exp 0", r_mv_after); else pass_cnt++;
  endtask

  task automatic test_stall();
    va[0] = -3; va[1] = 7;  va[2] = -1;
    vb[0] = 4;  vb[1] = -2; vb[2] = -5;
    run_vector(3, 2, 1, 1, 1'b0);
    total_cnt++; if (r_res !== AW'(-21)) $display("FAIL stall_result got %0d exp -21", $signed(r_res)); else pass_cnt++;
    total_cnt++; if (r_busy_ok !== 1'b1) $display("FAIL stall_busy got %b exp 1", r_busy_ok); else pass_cnt++;
    total_cnt++; if (r_err !== 1'b0) $display("FAIL stall_error got %b exp 0", r_err); else pass_cnt++;
  endtask

  task automatic test_zero_len();
    run_vector(0, -1, 0, 1, 1'b0);
    total_cnt++; if (r_lat !== 0) $display("FAIL zero_latency got %0d exp 0", r_lat); else pass_cnt++;
    total_cnt++; if (r_res !== '0) $display("FAIL zero_result got %h exp 0", r_res); else pass_cnt++;
    total_cnt++; if (r_err !== 1'b0) $display("FAIL zero_error got %b exp 0", r_err); else pass_cnt++;
    total_cnt++; if (r_rdy_seen !== 1'b0) $display("FAIL zero_sready got %b exp 0", r_rdy_seen); else pass_cnt++;
  endtask

  task automatic test_len_mismatch();
    for (int i = 0; i < 4; i++) begin va[i] = $urandom_range(0, 200) - 100; vb[i] = $urandom_range(0, 200) - 100; end
    model(4, 1, e_res, e_err, e_ovf);
    run_vector(4, 1, 0, 0, 1'b0);
    total_cnt++; if (r_tmo !== 1'b0) $display("FAIL mism_timeout got %b exp 0", r_tmo); else pass_cnt++;
    total_cnt++; if (r_err !== 1'b1) $display("FAIL mism_error got %b exp 1", r_err); else pass_cnt++;
    total_cnt++; if (r_res !== e_res) $display("FAIL mism_result got %h exp %h", r_res, e_res); else pass_cnt++;
    model(4, 3, e_res, e_err, e_ovf);
    run_vector(4, 3, 0, 0, 1'b0);
    total_cnt++; if (r_err !== 1'b0) $display("FAIL clean_error got %b exp 0", r_err); else pass_cnt++;
    total_cnt++; if (r_res !== e_res) $display("FAIL clean_result got %h exp %h", r_res, e_res); else pass_cnt++;
  endtask

  task automatic test_overflow();
    logic [AW-1:0] k_res;
    logic          k_ovf;
    for (int i = 0; i < 3; i++) begin va[i] = 32'h7FFF_FFFF; vb[i] = 32'h7FFF_FFFF; end
`ifdef DOT_SATURATE_EN
    k_res = 64'h7FFF_FFFF_FFFF_FFFF; k_ovf = 1'b1;
`else
    // 3 * (2^31-1)^2 = 3 * 0x3FFFFFFF00000001, reduced mod 2^64
    k_res = 64'hBFFF_FFFD_0000_0003; k_ovf = 1'b0;
`endif
    run_vector(3, 2, 0, 0, 1'b0);
    total_cnt++; if (r_res !== k_res) $display("FAIL ovf_result got %h exp %h", r_res, k_res); else pass_cnt++;
    total_cnt++; if (r_ovf !== k_ovf) $display("FAIL ovf_flag got %b exp %b", r_ovf, k_ovf); else pass_cnt++;
    va[0] = 9; vb[0] = -9;
    run_vector(1, 0, 0, 0, 1'b0);
    total_cnt++; if (r_ovf !== 1'b0) $display("FAIL ovf_cleared got %b exp 0", r_ovf); else pass_cnt++;
    total_cnt++; if (r_res !== AW'(-81)) $display("FAIL ovf_next_result got %0d exp -81", $signed(r_res)); else pass_cnt++;
  endtask

  task automatic test_async_abort();
    int   beats, guard;
    logic rdy;
    for (int i = 0; i < 5; i++) begin va[i] = 10 + i; vb[i] = 3; end
    bus.start = 1'b1; bus.vec_len = LW'(5);
    @(posedge clk); #1;
    bus.start = 1'b0;
    beats = 0; guard = 0;
    while (beats < 2 && guard < 20) begin
      bus.s_valid = 1'b1; bus.s_a = va[beats]; bus.s_b = vb[beats]; bus.s_last = 1'b0;
      rdy = bus.s_ready;
      @(posedge clk); #1;
      if (rdy) beats++;
      guard++;
    end
    bus.s_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++; if ({bus.busy, bus.s_ready, bus.m_valid} !== 3'b000)
      $display("FAIL abort_outputs got %b exp 000", {bus.busy, bus.s_ready, bus.m_valid});
    else pass_cnt++;
    total_cnt++; if (bus.m_result !== '0) $display("FAIL abort_result got %h exp 0", bus.m_result); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (bus.m_valid !== 1'b0) $display("FAIL abort_hold_mvalid got %b exp 0", bus.m_valid); else pass_cnt++;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    va[0] = 2; va[1] = 2; vb[0] = 3; vb[1] = 3;
    run_vector(2, 1, 0, 0, 1'b0);
    total_cnt++; if (r_res !== AW'(12)) $display("FAIL abort_next_result got %0d exp 12", $signed(r_res)); else pass_cnt++;
    total_cnt++; if (r_err !== 1'b0) $display("FAIL abort_next_error got %b exp 0", r_err); else pass_cnt++;
  endtask

  task automatic test_random();
    int n, last_idx, r;
    for (int t = 0; t < 25; t++) begin
      n = $urandom_range(1, 10);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 1) == 0) begin
          va[i] = $urandom_range(0, 200) - 100; vb[i] = $urandom_range(0, 200) - 100;
        end else begin
          va[i] = $urandom; vb[i] = $urandom;
        end
      end
      r = $urandom_range(0, 9);
      if (r < 7) last_idx = n - 1;
      else if (r < 9) last_idx = $urandom_range(0, n - 1);
      else last_idx = n;
      model(n, last_idx, e_res, e_err, e_ovf);
      run_vector(n, last_idx, $urandom_range(0, 2), $urandom_range(0, 3), 1'b0);
      total_cnt++; if (r_res !== e_res) $display("FAIL rand_result[%0d] got %h exp %h", t, r_res, e_res); else pass_cnt++;
      total_cnt++; if (r_err !== e_err) $display("FAIL rand_error[%0d] got %b exp %b", t, r_err, e_err); else pass_cnt++;
      total_cnt++; if (r_ovf !== e_ovf) $display("FAIL rand_ovf[%0d] got %b exp %b", t, r_ovf, e_ovf); else pass_cnt++;
      total_cnt++; if (r_lat !== 2) $display("FAIL rand_latency[%0d] got %0d exp 2", t, r_lat); else pass_cnt++;
      total_cnt++; if (r_hold_ok !== 1'b1) $display("FAIL rand_hold[%0d] got %b exp 1", t, r_hold_ok); else pass_cnt++;
      total_cnt++; if (r_mv_after !== 1'b0) $display("FAIL rand_mvalid_drop[%0d] got %b exp 0", t, r_mv_after); else pass_cnt++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0; bus.vec_len = '0; bus.s_valid = 1'b0;
    bus.s_a = '0; bus.s_b = '0; bus.s_last = 1'b0; bus.m_ready = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_zero_len();
    test_len_mismatch();
    test_overflow();
    test_async_abort();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
